// File: rtl/serial_parallel_align.sv
// -----------------------------------------------------------------------------
// serial_parallel_align
//
// Receive-side deserialiser for one PHY lane. Serial bits arrive on every
// rising edge of the fast bit clock and are shifted into a WIDTH-bit window.
// The block hunts for the COMMA symbol to find word alignment. It declares lock
// after LOCK_COUNT consecutive commas on word boundaries. While locked, it
// presents each completed word with a valid qualifier and a one-cycle strobe.
// With REALIGN_EN set, a comma seen off the word boundary while locked forces
// the block back into alignment.
//
// Ports
//   clk_32f      in   1      bit clock, the only clock; all logic on rising edge
//   reset        in   1      synchronous active-high reset
//   data_in      in   1      serial bit, sampled on every edge
//   data_out     out  WIDTH  last word captured on a boundary while locked
//   valid_out    out  1      data_out holds a valid non-comma word
//   word_strobe  out  1      one-cycle pulse when data_out/valid_out update
//   locked       out  1      high while in the LOCKED state
//   realign      out  1      one-cycle pulse when an off-boundary comma
//                            forces realignment
// -----------------------------------------------------------------------------
module serial_parallel_align #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter bit               MSB_FIRST  = 1'b1,
    parameter bit               REALIGN_EN = 1'b1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_strobe,
    output logic             locked,
    output logic             realign
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W:0]   LOCK_WIDE   = (CNT_W + 1)'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT,
        ALIGN,
        LOCKED
    } state_e;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] shiftReg_q,  shiftReg_d;
    logic [BIT_W-1:0] bitCnt_q,    bitCnt_d;
    logic [CNT_W-1:0] commaCnt_q,  commaCnt_d;
    logic [WIDTH-1:0] dataOut_q,   dataOut_d;
    logic             validOut_q,  validOut_d;
    logic             strobe_q,    strobe_d;
    logic             realign_q,   realign_d;

    logic             isComma;
    logic             boundary;
    logic [CNT_W:0]   commaInc;

    // The new window includes the bit arriving on this edge, so every comma
    // decision is made on the same edge that samples the comma's last bit.
    always_comb begin
        if (MSB_FIRST) begin
            shiftReg_d = {shiftReg_q[WIDTH-2:0], data_in};
        end else begin
            shiftReg_d = {data_in, shiftReg_q[WIDTH-1:1]};
        end
        isComma  = (shiftReg_d == COMMA);
        boundary = (bitCnt_q == LAST_BIT);
        commaInc = {1'b0, commaCnt_q} + 1'b1;
    end

    // State and datapath registers. Reset takes priority over everything,
    // including a word in flight or an established lock.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= HUNT;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            commaCnt_q <= '0;
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
            strobe_q   <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            commaCnt_q <= commaCnt_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            strobe_q   <= strobe_d;
            realign_q  <= realign_d;
        end
    end

    // Next-state logic. Resetting bitCnt to zero on a detected comma makes the
    // following bit the first bit of a word. In LOCKED, a comma on the boundary
    // is an ordinary word, so the boundary branch is checked first.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = boundary ? '0 : bitCnt_q + 1'b1;
        commaCnt_d = commaCnt_q;
        dataOut_d  = dataOut_q;
        validOut_d = validOut_q;
        strobe_d   = 1'b0;
        realign_d  = 1'b0;

        case (state_q)
            HUNT: begin
                if (isComma) begin
                    bitCnt_d   = '0;
                    commaCnt_d = CNT_W'(1);
                    if (LOCK_COUNT == 1) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (isComma) begin
                        if (commaInc >= LOCK_WIDE) begin
                            commaCnt_d = LOCK_TARGET;
                            state_d    = LOCKED;
                        end else begin
                            commaCnt_d = commaInc[CNT_W-1:0];
                        end
                    end else begin
                        commaCnt_d = '0;
                        state_d    = HUNT;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    dataOut_d  = shiftReg_d;
                    strobe_d   = 1'b1;
                    validOut_d = !isComma;
                end else if (REALIGN_EN && isComma) begin
                    bitCnt_d   = '0;
                    validOut_d = 1'b0;
                    realign_d  = 1'b1;
                    commaCnt_d = CNT_W'(1);
                    if (LOCK_COUNT != 1) begin
                        state_d = ALIGN;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // Outputs come straight from registers; locked is a decode of the state.
    always_comb begin
        data_out    = dataOut_q;
        valid_out   = validOut_q;
        word_strobe = strobe_q;
        locked      = (state_q == LOCKED);
        realign     = realign_q;
    end

endmodule

// File: tb/tb_serial_parallel_align.sv
// -----------------------------------------------------------------------------
// tb_serial_parallel_align
//
// Self-checking bench for serial_parallel_align. Three instances cover the
// default configuration, the same with realignment disabled, and a 10-bit
// LSB-first variant with single-comma lock. A behavioural model tracks each
// instance from the bit history and the absolute position of the last
// alignment point; it predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_serial_parallel_align;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;
    logic       dinA = 1'b0, dinB = 1'b0, dinC = 1'b0;
    logic [7:0] doutA, doutB;
    logic [9:0] doutC;
    logic       validA, validB, validC;
    logic       strobeA, strobeB, strobeC;
    logic       lockedA, lockedB, lockedC;
    logic       realignA, realignB, realignC;

    serial_parallel_align #(
        .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MSB_FIRST(1'b1), .REALIGN_EN(1'b1)
    ) dutA (
        .clk_32f(clk), .reset(rstA), .data_in(dinA), .data_out(doutA),
        .valid_out(validA), .word_strobe(strobeA), .locked(lockedA), .realign(realignA)
    );

    serial_parallel_align #(
        .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MSB_FIRST(1'b1), .REALIGN_EN(1'b0)
    ) dutB (
        .clk_32f(clk), .reset(rstB), .data_in(dinB), .data_out(doutB),
        .valid_out(validB), .word_strobe(strobeB), .locked(lockedB), .realign(realignB)
    );

    serial_parallel_align #(
        .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1), .MSB_FIRST(1'b0), .REALIGN_EN(1'b1)
    ) dutC (
        .clk_32f(clk), .reset(rstC), .data_in(dinC), .data_out(doutC),
        .valid_out(validC), .word_strobe(strobeC), .locked(lockedC), .realign(realignC)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: mode 0 hunting, 1 counting commas, 2 locked.
    typedef struct {
        int          w;
        int          comma;
        int          lockCount;
        bit          msbFirst;
        bit          realignEn;
        int          mode;
        longint      n;
        longint      alignStart;
        int          commas;
        logic [63:0] hist;
        int          dout;
        bit          valid;
        bit          strobe;
        bit          realign;
    } model_t;

    model_t mdl [3];

    bit stim  [$];
    int sWord [$];
    int sCyc  [$];
    bit sVal  [$];

    function automatic void modelReset(int idx);
        mdl[idx].mode       = 0;
        mdl[idx].n          = 0;
        mdl[idx].alignStart = 0;
        mdl[idx].commas     = 0;
        mdl[idx].hist       = '0;
        mdl[idx].dout       = 0;
        mdl[idx].valid      = 1'b0;
        mdl[idx].strobe     = 1'b0;
        mdl[idx].realign    = 1'b0;
    endfunction

    function automatic void modelStep(int idx, bit b);
        model_t m;
        int     word;
        bit     isComma;
        bit     bnd;
        m      = mdl[idx];
        word   = 0;
        m.hist = {m.hist[62:0], b};
        for (int i = 0; i < m.w; i++) begin
            if (m.msbFirst) word |= int'(m.hist[i]) << i;
            else            word |= int'(m.hist[i]) << (m.w - 1 - i);
        end
        isComma   = (word == m.comma);
        bnd       = ((m.n - m.alignStart) % m.w) == longint'(m.w - 1);
        m.strobe  = 1'b0;
        m.realign = 1'b0;
        case (m.mode)
            0: begin
                if (isComma) begin
                    m.alignStart = m.n + 1;
                    m.commas     = 1;
                    m.mode       = (m.lockCount == 1) ? 2 : 1;
                end
            end
            1: begin
                if (bnd) begin
                    if (isComma) begin
                        m.commas = (m.commas + 1 > m.lockCount) ? m.lockCount : m.commas + 1;
                        if (m.commas == m.lockCount) m.mode = 2;
                    end else begin
                        m.mode   = 0;
                        m.commas = 0;
                    end
                end
            end
            default: begin
                if (bnd) begin
                    m.dout   = word;
                    m.strobe = 1'b1;
                    m.valid  = !isComma;
                end else if (isComma && m.realignEn) begin
                    m.alignStart = m.n + 1;
                    m.valid      = 1'b0;
                    m.realign    = 1'b1;
                    m.commas     = 1;
                    if (m.lockCount > 1) m.mode = 1;
                end
            end
        endcase
        m.n++;
        mdl[idx] = m;
    endfunction

    function automatic logic [19:0] expVec(int idx);
        return {mdl[idx].mode == 2, mdl[idx].strobe, mdl[idx].valid,
                mdl[idx].realign, 16'(mdl[idx].dout)};
    endfunction

    function automatic logic [19:0] getObs(int idx);
        case (idx)
            0:       return {lockedA, strobeA, validA, realignA, 8'h00, doutA};
            1:       return {lockedB, strobeB, validB, realignB, 8'h00, doutB};
            default: return {lockedC, strobeC, validC, realignC, 6'h00, doutC};
        endcase
    endfunction

    task automatic pushWord(int w, int width, bit msb);
        for (int k = 0; k < width; k++) begin
            if (msb) stim.push_back(bit'((w >> (width - 1 - k)) & 1));
            else     stim.push_back(bit'((w >> k) & 1));
        end
    endtask

    task automatic stepBit(int idx, bit b);
        case (idx)
            0:       dinA = b;
            1:       dinB = b;
            default: dinC = b;
        endcase
        @(posedge clk);
        modelStep(idx, b);
        #1;
    endtask

    task automatic doReset(int idx, int cycles);
        case (idx)
            0:       begin rstA = 1'b1; dinA = 1'b0; end
            1:       begin rstB = 1'b1; dinB = 1'b0; end
            default: begin rstC = 1'b1; dinC = 1'b0; end
        endcase
        repeat (cycles) @(posedge clk);
        modelReset(idx);
        #1;
        case (idx)
            0:       rstA = 1'b0;
            1:       rstB = 1'b0;
            default: rstC = 1'b0;
        endcase
    endtask

    task automatic buildMisalignedStim();
        stim.delete();
        repeat (4)  pushWord(8'hBC, 8, 1'b1);
        repeat (11) pushWord(8'h00, 8, 1'b1);
        repeat (3)  stim.push_back(1'b0);
        repeat (4)  pushWord(8'hBC, 8, 1'b1);
        pushWord(8'hAA, 8, 1'b1);
    endtask

    task automatic test_reset();
        doReset(0, 3);
        vectors++; if (doutA !== 8'h00)  begin miscompares++; $display("[TB] FAIL reset_data_out got %h exp 00", doutA); end
        vectors++; if (validA !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_valid got %b exp 0", validA); end
        vectors++; if (strobeA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobe got %b exp 0", strobeA); end
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked got %b exp 0", lockedA); end
        vectors++; if (realignA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_realign got %b exp 0", realignA); end
    endtask

    task automatic test_basic_lock();
        int expW [7] = '{8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hBC, 8'hFF, 8'h00};
        bit expV [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        stim.delete();
        pushWord(8'hAA, 8, 1'b1);
        repeat (4) pushWord(8'hBC, 8, 1'b1);
        foreach (expW[k]) pushWord(expW[k], 8, 1'b1);
        sWord.delete(); sCyc.delete(); sVal.delete();
        doReset(1, 3);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(1, stim[i]);
            vectors++;
            if (getObs(1) !== expVec(1)) begin
                miscompares++;
                $display("[TB] FAIL basic_model bit %0d got %h exp %h", i, getObs(1), expVec(1));
            end
            if (i == 38 || i == 39) begin
                vectors++;
                if (lockedB !== (i == 39)) begin
                    miscompares++;
                    $display("[TB] FAIL basic_lock_edge bit %0d got %b exp %b", i, lockedB, i == 39);
                end
            end
            if (strobeB === 1'b1) begin
                sWord.push_back(int'(doutB)); sCyc.push_back(i); sVal.push_back(validB);
            end
        end
        vectors++;
        if (sWord.size() != 7) begin
            miscompares++;
            $display("[TB] FAIL basic_strobe_count got %0d exp 7", sWord.size());
        end
        for (int k = 0; k < 7 && k < sWord.size(); k++) begin
            vectors++;
            if (sWord[k] != expW[k] || sVal[k] != expV[k] || sCyc[k] != 47 + 8 * k) begin
                miscompares++;
                $display("[TB] FAIL basic_strobe_%0d got %h/%b@%0d exp %h/%b@%0d",
                         k, sWord[k], sVal[k], sCyc[k], expW[k], expV[k], 47 + 8 * k);
            end
        end
        // Same stream on the realigning instance, judged by the model alone.
        doReset(0, 3);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(0, stim[i]);
            vectors++;
            if (getObs(0) !== expVec(0)) begin
                miscompares++;
                $display("[TB] FAIL basic_realign_model bit %0d got %h exp %h", i, getObs(0), expVec(0));
            end
        end
    endtask

    task automatic test_broken_lock();
        stim.delete();
        repeat (3) pushWord(8'hBC, 8, 1'b1);
        pushWord(8'h55, 8, 1'b1);
        repeat (4) pushWord(8'hBC, 8, 1'b1);
        pushWord(8'hDD, 8, 1'b1);
        doReset(1, 1);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(1, stim[i]);
            vectors++;
            if (getObs(1) !== expVec(1)) begin
                miscompares++;
                $display("[TB] FAIL broken_model bit %0d got %h exp %h", i, getObs(1), expVec(1));
            end
            vectors++;
            if (strobeB !== (i == 71) || lockedB !== (i >= 63)) begin
                miscompares++;
                $display("[TB] FAIL broken_flow bit %0d got s%b l%b exp s%b l%b",
                         i, strobeB, lockedB, i == 71, i >= 63);
            end
            if (i == 71) begin
                vectors++;
                if (doutB !== 8'hDD || validB !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL broken_first_word got %h/%b exp dd/1", doutB, validB);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        buildMisalignedStim();
        doReset(0, 2);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(0, stim[i]);
            vectors++;
            if (getObs(0) !== expVec(0)) begin
                miscompares++;
                $display("[TB] FAIL misalign_model bit %0d got %h exp %h", i, getObs(0), expVec(0));
            end
            vectors++;
            if (realignA !== (i == 130)) begin
                miscompares++;
                $display("[TB] FAIL misalign_pulse bit %0d got %b exp %b", i, realignA, i == 130);
            end
            if (i == 130) begin
                vectors++;
                if (lockedA !== 1'b0 || validA !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL misalign_drop got l%b v%b exp l0 v0", lockedA, validA);
                end
            end
            if (i == 153 || i == 154) begin
                vectors++;
                if (lockedA !== (i == 154)) begin
                    miscompares++;
                    $display("[TB] FAIL misalign_relock bit %0d got %b exp %b", i, lockedA, i == 154);
                end
            end
            if (i == 162) begin
                vectors++;
                if (strobeA !== 1'b1 || doutA !== 8'hAA || validA !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL misalign_word got s%b %h v%b exp s1 aa v1", strobeA, doutA, validA);
                end
            end
        end
    endtask

    task automatic test_realign_disabled();
        bit expStrobe;
        buildMisalignedStim();
        doReset(1, 2);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(1, stim[i]);
            expStrobe = (i >= 39) && ((i - 39) % 8 == 0);
            vectors++;
            if (getObs(1) !== expVec(1)) begin
                miscompares++;
                $display("[TB] FAIL noalign_model bit %0d got %h exp %h", i, getObs(1), expVec(1));
            end
            vectors++;
            if (lockedB !== (i >= 31) || realignB !== 1'b0 || strobeB !== expStrobe) begin
                miscompares++;
                $display("[TB] FAIL noalign_cadence bit %0d got l%b r%b s%b exp l%b r0 s%b",
                         i, lockedB, realignB, strobeB, i >= 31, expStrobe);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        stim.delete();
        repeat (4) pushWord(8'hBC, 8, 1'b1);
        pushWord(8'h5A, 8, 1'b1);
        stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
        doReset(0, 1);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(0, stim[i]);
            vectors++;
            if (getObs(0) !== expVec(0)) begin
                miscompares++;
                $display("[TB] FAIL midreset_model bit %0d got %h exp %h", i, getObs(0), expVec(0));
            end
        end
        vectors++;
        if (lockedA !== 1'b1 || validA !== 1'b1 || doutA !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL midreset_prelock got l%b v%b %h exp l1 v1 5a", lockedA, validA, doutA);
        end
        doReset(0, 1);
        vectors++;
        if ({doutA, validA, strobeA, lockedA, realignA} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL midreset_clear got %h/%b%b%b%b exp 00/0000",
                     doutA, validA, strobeA, lockedA, realignA);
        end
        stim.delete();
        repeat (4) pushWord(8'hBC, 8, 1'b1);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(0, stim[i]);
            vectors++;
            if (lockedA !== (i == 31)) begin
                miscompares++;
                $display("[TB] FAIL midreset_relock bit %0d got %b exp %b", i, lockedA, i == 31);
            end
        end
    endtask

    task automatic test_param_sweep();
        int words [7] = '{10'h17C, 10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h17C, 10'h3FF};
        stim.delete();
        foreach (words[k]) pushWord(words[k], 10, 1'b0);
        sWord.delete(); sCyc.delete(); sVal.delete();
        doReset(2, 2);
        for (int i = 0; i < stim.size(); i++) begin
            stepBit(2, stim[i]);
            vectors++;
            if (getObs(2) !== expVec(2)) begin
                miscompares++;
                $display("[TB] FAIL sweep_model bit %0d got %h exp %h", i, getObs(2), expVec(2));
            end
            vectors++;
            if (lockedC !== (i >= 9) || realignC !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL sweep_lock bit %0d got l%b r%b exp l%b r0", i, lockedC, realignC, i >= 9);
            end
            if (strobeC === 1'b1) begin
                sWord.push_back(int'(doutC)); sCyc.push_back(i); sVal.push_back(validC);
            end
        end
        vectors++;
        if (sWord.size() != 6) begin
            miscompares++;
            $display("[TB] FAIL sweep_strobe_count got %0d exp 6", sWord.size());
        end
        for (int k = 0; k < 6 && k < sWord.size(); k++) begin
            vectors++;
            if (sWord[k] != words[k + 1] || sVal[k] != (words[k + 1] != 10'h17C) || sCyc[k] != 19 + 10 * k) begin
                miscompares++;
                $display("[TB] FAIL sweep_word_%0d got %h/%b@%0d exp %h/%b@%0d", k, sWord[k], sVal[k],
                         sCyc[k], words[k + 1], words[k + 1] != 10'h17C, 19 + 10 * k);
            end
        end
    endtask

    task automatic test_random();
        int width;
        int comma;
        int r;
        for (int idx = 0; idx < 3; idx++) begin
            width = (idx == 2) ? 10 : 8;
            comma = (idx == 2) ? 10'h17C : 8'hBC;
            stim.delete();
            for (int k = 0; k < 70; k++) begin
                r = int'($urandom_range(0, 9));
                if (r < 3) begin
                    pushWord(comma, width, idx != 2);
                end else if (r == 3) begin
                    repeat (int'($urandom_range(1, width - 1))) stim.push_back(bit'($urandom_range(0, 1)));
                end else begin
                    pushWord(int'($urandom_range(0, (1 << width) - 1)), width, idx != 2);
                end
            end
            doReset(idx, 1);
            for (int i = 0; i < stim.size(); i++) begin
                stepBit(idx, stim[i]);
                vectors++;
                if (getObs(idx) !== expVec(idx)) begin
                    miscompares++;
                    $display("[TB] FAIL random_model dut %0d bit %0d got %h exp %h",
                             idx, i, getObs(idx), expVec(idx));
                end
            end
        end
    endtask

    initial begin
        mdl[0] = '{w: 8,  comma: 8'hBC,   lockCount: 4, msbFirst: 1'b1, realignEn: 1'b1, default: 0};
        mdl[1] = '{w: 8,  comma: 8'hBC,   lockCount: 4, msbFirst: 1'b1, realignEn: 1'b0, default: 0};
        mdl[2] = '{w: 10, comma: 10'h17C, lockCount: 1, msbFirst: 1'b0, realignEn: 1'b1, default: 0};
        for (int i = 0; i < 3; i++) modelReset(i);
        test_reset();
        test_basic_lock();
        test_broken_lock();
        test_misaligned();
        test_realign_disabled();
        test_reset_mid_lock();
        test_param_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_parallel_align.md
# serial_parallel_align

Parametrised serial-to-parallel converter for the receive side of the PHY lane. It deserialises a bit stream sampled on the fast bit clock and finds word alignment by hunting for a comma symbol. It declares lock after a programmable number of consecutive aligned commas, then emits parallel words with a per-word valid qualifier. Its optional realignment mode re-hunts when a comma appears off the word boundary.

## Interface
- WIDTH, 8: word width in bits (≥2).
- COMMA, 8'hBC: alignment symbol, WIDTH bits.
- LOCK_COUNT, 4: consecutive aligned commas required for lock (≥1).
- MSB_FIRST, 1: 1 = first serial bit of a word is data_out[WIDTH-1]; 0 = first bit is data_out[0].
- REALIGN_EN, 1: 1 = an off-boundary comma while LOCKED forces realignment.
- clk_32f  input  1  bit clock; all logic on its rising edge; only clock.
- reset  input  1  synchronous, active-high.
- data_in  input  1  serial bit, sampled every clk_32f edge.
- data_out  output  WIDTH  last parallel word captured while LOCKED.
- valid_out  output  1  data_out is a valid non-comma word.
- word_strobe  output  1  one-cycle pulse when data_out/valid_out update.
- locked  output  1  high in LOCKED.
- realign  output  1  one-cycle pulse on loss of lock by off-boundary comma.

## Operation
- The shift register is updated every edge with data_in.
  - sr_next = {sr[W-2:0], data_in} when MSB_FIRST=1.
  - sr_next = {data_in, sr[W-1:1]} when MSB_FIRST=0.
  - All comparisons use sr_next, i.e. the word including the bit present this edge.
- bit_cnt counts 0..WIDTH-1 and wraps to 0. Boundary = edge where bit_cnt==WIDTH-1.
- The state machine has three states: HUNT, ALIGN and LOCKED. Reset state is HUNT with bit_cnt=0 and comma_cnt=0.
- HUNT: on any edge with sr_next==COMMA:
  - set bit_cnt<=0, so the next bit is the first bit of a word;
  - if LOCK_COUNT==1, go to LOCKED; otherwise set comma_cnt<=1 and go to ALIGN.
- ALIGN:
  - On a boundary with sr_next==COMMA: comma_cnt++. When the incremented value equals LOCK_COUNT, go to LOCKED.
  - On a boundary with a non-comma word: go to HUNT and set comma_cnt<=0.
  - Non-boundary comma matches are ignored in ALIGN.
- LOCKED, on each boundary:
  - data_out<=sr_next, word_strobe<=1, valid_out<=(sr_next!=COMMA).
  - Commas keep lock and are reported with valid_out=0.
- LOCKED, on a non-boundary edge with sr_next==COMMA and REALIGN_EN=1:
  - set bit_cnt<=0 and valid_out<=0, pulse realign;
  - comma_cnt<=1 and go to ALIGN; if LOCK_COUNT==1, stay LOCKED realigned.
  - When REALIGN_EN=0, such matches are ignored.
- data_out and valid_out hold between boundaries. data_out holds its last value outside LOCKED.
- Leaving LOCKED clears valid_out on the same edge.
- comma_cnt saturates at LOCK_COUNT. Its width is $clog2(LOCK_COUNT+1).

## Timing
- Reset (synchronous, high on an edge): data_out=0, valid_out=0, word_strobe=0, locked=0, realign=0, sr=0, state=HUNT.
  - reset overrides all other activity, including mid-word or mid-lock.
  - The first data_in sample taken is from the first edge after reset deasserts.
- Latency: the last bit of a word is on data_in at edge t. data_out, valid_out and word_strobe are visible after edge t, i.e. one clk_32f cycle.
- In steady LOCKED, word_strobe pulses exactly every WIDTH cycles.
- locked rises after the edge that samples the last bit of the LOCK_COUNT-th comma. It falls after the edge that detects a misaligned comma or a non-comma word in ALIGN.
- A boundary comma in LOCKED is not a misaligned comma. The boundary rule takes precedence.

## Test plan
- Basic lock (WIDTH=8, COMMA=BC, LOCK_COUNT=4, MSB_FIRST=1):
  - stimulus: reset 3 cycles, then serial AA, BC×4, BB, CC, DD, EE, BC, FF, 00;
  - required: locked=1 one cycle after the last bit of the 4th BC;
  - required: strobes carry BB, CC, DD, EE, FF, 00 with valid_out=1, and BC with valid_out=0;
  - required: strobes are spaced exactly 8 cycles apart.
- Broken lock sequence:
  - stimulus: BC×3, then 55, then BC×4, DD;
  - required: after 55, state is HUNT and locked=0; no strobe occurs before the second BC×4 completes; the first valid word is DD.
- Misaligned comma:
  - stimulus: locked stream of 11 words, then 3 filler bits, then BC×4, AA;
  - required: realign pulses one cycle after the last BC bit; locked=0 and valid_out=0 on the same edge;
  - required: relock follows after 3 more aligned BCs; AA is output valid.
- REALIGN_EN=0:
  - stimulus: same as the misaligned-comma case;
  - required: locked stays 1, no realign pulse, and the 8-cycle strobe cadence is unchanged.
- Reset mid-lock:
  - stimulus: assert reset during the 4th bit of a data word while locked;
  - required: all outputs are 0 after that edge, and a full BC×4 is needed to relock.
- Parameter sweep:
  - stimulus: WIDTH=10, COMMA=10'h17C, LOCK_COUNT=1, MSB_FIRST=0, LSB-first stream;
  - required: lock on the first comma; words are reconstructed bit-exact; strobes are spaced 10 cycles apart.
